// File: rtl/xbar_pkg.sv
// ----------------------------------------------------------------------------
// xbar_pkg
//   Crossbar geometry and loader state encoding, shared between the config
//   loader and the tile-level crossbar instantiation.
//   No ports (package).
// ----------------------------------------------------------------------------
package xbar_pkg;

    localparam int NUM_IN    = 33;                              // legal selects 0..NUM_IN-1
    localparam int NUM_OUT   = 40;                              // one select field per output
    localparam int SEL_W     = 6;                               // bits per select field
    localparam int WORD_W    = 16;                              // config stream word width
    localparam int CFG_W     = NUM_OUT * SEL_W;                 // 240 config bits
    localparam int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;   // 15 words per image
    localparam int SHADOW_W  = NUM_WORDS * WORD_W;              // shadow incl. last-word padding
    localparam int WCNT_W    = $clog2(NUM_WORDS);
    localparam int FIDX_W    = $clog2(NUM_OUT);
    localparam int EPOCH_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } xbar_ld_state_t;

endpackage

// File: rtl/xbar_cfg_loader_if.sv
// ----------------------------------------------------------------------------
// xbar_cfg_loader_if
//   Control, config-stream and status signals of the crossbar config loader.
//   slave  : the loader (consumes start/abort/stream, drives status + config)
//   master : the controller / stream source
//   io_start, io_abort      : load control
//   io_cfg_valid/ready/data : config word stream
//   io_busy, io_done, io_err: status
//   io_cfg_epoch            : successful-commit counter
//   io_mux_configs          : active crossbar select image
// ----------------------------------------------------------------------------
interface xbar_cfg_loader_if;
    import xbar_pkg::*;

    logic                 io_start;
    logic                 io_abort;
    logic                 io_cfg_valid;
    logic                 io_cfg_ready;
    logic [WORD_W-1:0]    io_cfg_data;
    logic                 io_busy;
    logic                 io_done;
    logic                 io_err;
    logic [EPOCH_W-1:0]   io_cfg_epoch;
    logic [CFG_W-1:0]     io_mux_configs;

    modport slave (
        input  io_start, io_abort, io_cfg_valid, io_cfg_data,
        output io_cfg_ready, io_busy, io_done, io_err, io_cfg_epoch, io_mux_configs
    );

    modport master (
        output io_start, io_abort, io_cfg_valid, io_cfg_data,
        input  io_cfg_ready, io_busy, io_done, io_err, io_cfg_epoch, io_mux_configs
    );

endinterface

// File: rtl/xbar_cfg_loader.sv
// ----------------------------------------------------------------------------
// xbar_cfg_loader
//   Loads a crossbar select image word by word into a shadow register, range
//   checks every select field (one per cycle) and only then commits the image
//   to io_mux_configs in a single edge, so the crossbar never sees a partial
//   or illegal configuration.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : xbar_cfg_loader_if.slave (control, stream, status, active config)
// ----------------------------------------------------------------------------
module xbar_cfg_loader
    import xbar_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    xbar_cfg_loader_if.slave    bus
);

    xbar_ld_state_t         state;
    logic [WCNT_W-1:0]      word_cnt;
    logic [FIDX_W-1:0]      field_idx;
    logic                   err_pend;
    logic                   cfg_ready;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [EPOCH_W-1:0]     epoch;
    logic [CFG_W-1:0]       mux_configs;
    logic [SHADOW_W-1:0]    shadow;
    logic [SEL_W-1:0]       cur_field;
    logic                   field_bad;
    logic                   handshake;

    assign handshake = bus.io_cfg_valid && cfg_ready;

    // Field under test this CHECK cycle and its range comparison.
    assign cur_field = shadow[int'(field_idx) * SEL_W +: SEL_W];
    assign field_bad = (cur_field >= SEL_W'(NUM_IN));

    // Shadow is pure data: no reset, contents after an abort are don't-care.
    always_ff @(posedge clk) begin
        if (state == LOAD && handshake) begin
            shadow[int'(word_cnt) * WORD_W +: WORD_W] <= bus.io_cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            word_cnt    <= '0;
            field_idx   <= '0;
            err_pend    <= 1'b0;
            cfg_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            epoch       <= '0;
            mux_configs <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Abort takes priority over a simultaneous start.
                    if (!bus.io_abort && bus.io_start) begin
                        state     <= LOAD;
                        word_cnt  <= '0;
                        err       <= 1'b0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    // Abort wins even against the final word's handshake.
                    if (bus.io_abort) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b0;
                    end else if (handshake) begin
                        if (word_cnt == WCNT_W'(NUM_WORDS - 1)) begin
                            state     <= CHECK;
                            cfg_ready <= 1'b0;
                            field_idx <= '0;
                            err_pend  <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    // Fixed NUM_OUT-cycle scan; an illegal field does not end it early.
                    if (bus.io_abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (field_bad) begin
                            err_pend <= 1'b1;
                        end
                        if (field_idx == FIDX_W'(NUM_OUT - 1)) begin
                            state <= COMMIT;
                        end else begin
                            field_idx <= field_idx + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    // Abort is not looked at here: the commit always completes.
                    if (!err_pend) begin
                        mux_configs <= shadow[CFG_W-1:0];
                        epoch       <= epoch + 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.io_cfg_ready   = cfg_ready;
    assign bus.io_busy        = busy;
    assign bus.io_done        = done;
    assign bus.io_err         = err;
    assign bus.io_cfg_epoch   = epoch;
    assign bus.io_mux_configs = mux_configs;

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// ----------------------------------------------------------------------------
// tb_xbar_cfg_loader
//   Self-checking bench for xbar_cfg_loader: table of load scenarios plus
//   hand-written reset / wrap sequences; commits are checked by a scoreboard.
// ----------------------------------------------------------------------------
module tb_xbar_cfg_loader;
    import xbar_pkg::*;

    logic clk;
    logic reset;
    int   cyc = 0;

    xbar_cfg_loader_if bus ();

    xbar_cfg_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    kind;      // image pattern
        int    bad_f;     // field to overwrite, -1 none
        int    bad_v;
        int    gap_pct;   // chance of a valid gap per cycle
        bit    xstart;    // extra io_start pulses during LOAD/CHECK
        int    ab_word;   // abort while presenting this word, -1 none
        int    ab_chk;    // abort at this CHECK cycle, -1 none
        bit    exp_done;
        bit    exp_err;
    } vec_t;

    typedef struct {
        logic [CFG_W-1:0]   cfg;
        logic               err;
        logic [EPOCH_W-1:0] epoch;
        int                 due;
    } exp_t;

    vec_t               vecs [10];
    exp_t               sb [$];
    int                 n_chk = 0;
    int                 n_fail = 0;
    int                 done_count = 0;
    logic [CFG_W-1:0]   model_cfg = '0;
    logic [EPOCH_W-1:0] model_epoch = '0;

    task automatic chk(input string name, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CFG_W-1:0] make_img(input int kind, input int bad_f, input int bad_v);
        logic [CFG_W-1:0] img;
        int v;
        img = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (kind == 0)      v = i % NUM_IN;
            else if (kind == 1) v = NUM_IN - 1;
            else                v = (i * 7 + 3) % NUM_IN;
            img[i*SEL_W +: SEL_W] = SEL_W'(v);
        end
        if (bad_f >= 0) img[bad_f*SEL_W +: SEL_W] = SEL_W'(bad_v);
        return img;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (bus.io_done === 1'b1) begin
            done_count++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("commit_cfg",     bus.io_mux_configs, e.cfg);
                chk("commit_err",     CFG_W'(bus.io_err), CFG_W'(e.err));
                chk("commit_epoch",   CFG_W'(bus.io_cfg_epoch), CFG_W'(e.epoch));
                chk("commit_latency", CFG_W'(cyc), CFG_W'(e.due));
            end
        end
    end

    task automatic expect_commit(input logic [CFG_W-1:0] img, input bit bad, input int t_last);
        exp_t e;
        if (!bad) begin
            model_cfg   = img;
            model_epoch = model_epoch + 1'b1;
        end
        e.cfg   = model_cfg;
        e.err   = bad;
        e.epoch = model_epoch;
        e.due   = t_last + NUM_OUT + 1;
        sb.push_back(e);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", CFG_W'(sb.size()), '0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        bus.io_start = 1'b1;
        @(posedge clk); #1;
        bus.io_start = 1'b0;
    endtask

    task automatic load_words(input logic [CFG_W-1:0] img, output int t_last);
        int   k = 0;
        int   guard = 0;
        logic rdy;
        pulse_start();
        while (k < NUM_WORDS && guard < 200) begin
            bus.io_cfg_valid = 1'b1;
            bus.io_cfg_data  = img[k*WORD_W +: WORD_W];
            rdy = bus.io_cfg_ready;
            @(posedge clk); #1;
            if (rdy) k++;
            guard++;
        end
        bus.io_cfg_valid = 1'b0;
        if (k < NUM_WORDS) chk("load_timeout", CFG_W'(k), CFG_W'(NUM_WORDS));
        t_last = cyc;
    endtask

    task automatic run_vec(input vec_t v);
        logic [CFG_W-1:0] img;
        int   k = 0;
        int   guard = 0;
        int   t_last;
        int   dc0;
        bit   aborted = 0;
        logic rdy;
        logic ab;
        img = make_img(v.kind, v.bad_f, v.bad_v);
        dc0 = done_count;
        pulse_start();
        chk({v.name, "_start_busy"}, CFG_W'(bus.io_busy), CFG_W'(1));
        chk({v.name, "_start_clears_err"}, CFG_W'(bus.io_err), '0);
        while (k < NUM_WORDS && guard < 500) begin
            ab = (k == v.ab_word);
            bus.io_cfg_valid = ab || !(v.gap_pct > 0 && $urandom_range(99) < v.gap_pct);
            bus.io_cfg_data  = img[k*WORD_W +: WORD_W];
            bus.io_start     = v.xstart && ($urandom_range(3) == 0);
            bus.io_abort     = ab;
            rdy = bus.io_cfg_ready;
            @(posedge clk); #1;
            guard++;
            if (ab) begin
                aborted = 1;
                break;
            end
            if (bus.io_cfg_valid && rdy) k++;
        end
        bus.io_cfg_valid = 1'b0;
        bus.io_start     = 1'b0;
        bus.io_abort     = 1'b0;
        if (!aborted && k < NUM_WORDS) chk({v.name, "_load_timeout"}, CFG_W'(k), CFG_W'(NUM_WORDS));
        t_last = cyc;
        if (!aborted && v.ab_chk >= 0) begin
            repeat (v.ab_chk) begin
                @(posedge clk); #1;
            end
            bus.io_abort = 1'b1;
            @(posedge clk); #1;
            bus.io_abort = 1'b0;
            aborted = 1;
        end
        if (aborted) begin
            chk({v.name, "_abort_busy"},  CFG_W'(bus.io_busy), '0);
            chk({v.name, "_abort_ready"}, CFG_W'(bus.io_cfg_ready), '0);
            repeat (NUM_OUT + 5) begin
                @(posedge clk); #1;
            end
        end else begin
            if (v.xstart) begin
                repeat (10) begin
                    bus.io_start = 1'($urandom_range(1));
                    @(posedge clk); #1;
                end
                bus.io_start = 1'b0;
            end
            expect_commit(img, v.exp_err, t_last);
            drain(NUM_OUT + 20);
        end
        chk({v.name, "_done_seen"}, CFG_W'(done_count - dc0), CFG_W'(v.exp_done));
        chk({v.name, "_err"},       CFG_W'(bus.io_err), CFG_W'(v.exp_err));
        chk({v.name, "_cfg"},       bus.io_mux_configs, model_cfg);
        chk({v.name, "_epoch"},     CFG_W'(bus.io_cfg_epoch), CFG_W'(model_epoch));
    endtask

    // Behavioural crossbar driven by the active config: out[i] must be in[i%33].
    task automatic check_routing();
        logic [NUM_IN-1:0] din;
        logic [SEL_W-1:0]  sel;
        int                bad = 0;
        din = NUM_IN'({$urandom, $urandom});
        for (int i = 0; i < NUM_OUT; i++) begin
            sel = bus.io_mux_configs[i*SEL_W +: SEL_W];
            if (int'(sel) >= NUM_IN || din[sel] !== din[i % NUM_IN]) bad++;
        end
        chk("xbar_route", CFG_W'(bad), '0);
    endtask

    initial begin
        int t_last;
        int dc0;
        vecs[0] = '{"clean",      0, -1,  0,  0, 0, -1, -1, 1, 0};
        vecs[1] = '{"bad17",      0, 17, 40,  0, 0, -1, -1, 1, 1};
        vecs[2] = '{"gaps_start", 0, -1,  0, 50, 1, -1, -1, 1, 0};
        vecs[3] = '{"abort_w7",   0, -1,  0,  0, 0,  7, -1, 0, 0};
        vecs[4] = '{"abort_c20",  0, -1,  0,  0, 0, -1, 20, 0, 0};
        vecs[5] = '{"all32",      1, -1,  0, 30, 0, -1, -1, 1, 0};
        vecs[6] = '{"last_33",    2, 39, 33,  0, 0, -1, -1, 1, 1};
        vecs[7] = '{"first_63",   2,  0, 63,  0, 0, -1, -1, 1, 1};
        vecs[8] = '{"abort_last", 2, -1,  0,  0, 0, 14, -1, 0, 0};
        vecs[9] = '{"mixed",      2, -1,  0, 20, 0, -1, -1, 1, 0};

        bus.io_start     = 1'b0;
        bus.io_abort     = 1'b0;
        bus.io_cfg_valid = 1'b0;
        bus.io_cfg_data  = '0;
        reset            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg",   bus.io_mux_configs, '0);
        chk("rst_epoch", CFG_W'(bus.io_cfg_epoch), '0);
        reset = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("idle_cfg",   bus.io_mux_configs, '0);
        chk("idle_epoch", CFG_W'(bus.io_cfg_epoch), '0);
        chk("idle_ready", CFG_W'(bus.io_cfg_ready), '0);
        chk("idle_busy",  CFG_W'(bus.io_busy), '0);
        chk("idle_err",   CFG_W'(bus.io_err), '0);
        chk("idle_done",  CFG_W'(done_count), '0);

        // Start and abort together in IDLE: abort wins.
        bus.io_start = 1'b1;
        bus.io_abort = 1'b1;
        @(posedge clk); #1;
        bus.io_start = 1'b0;
        bus.io_abort = 1'b0;
        chk("start_abort_idle", CFG_W'(bus.io_busy), '0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
            if (i == 0) check_routing();
        end

        // Asynchronous reset in the middle of CHECK.
        load_words(make_img(2, -1, 0), t_last);
        repeat (10) @(posedge clk);
        #2;
        dc0 = done_count;
        reset = 1'b0;
        #1;
        chk("midchk_rst_cfg",   bus.io_mux_configs, '0);
        chk("midchk_rst_epoch", CFG_W'(bus.io_cfg_epoch), '0);
        chk("midchk_rst_busy",  CFG_W'(bus.io_busy), '0);
        chk("midchk_rst_ready", CFG_W'(bus.io_cfg_ready), '0);
        chk("midchk_rst_err",   CFG_W'(bus.io_err), '0);
        model_cfg   = '0;
        model_epoch = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (NUM_OUT + 5) begin
            @(posedge clk); #1;
        end
        chk("midchk_no_done", CFG_W'(done_count - dc0), '0);

        // 256 back-to-back successful commits: epoch wraps to 0.
        for (int n = 0; n < 256; n++) begin
            logic [CFG_W-1:0] img;
            img = make_img((n % 3 == 0) ? 0 : 2, -1, 0);
            img[0 +: SEL_W] = SEL_W'(n % NUM_IN);
            load_words(img, t_last);
            expect_commit(img, 1'b0, t_last);
            drain(NUM_OUT + 20);
            if (n == 254) chk("epoch_255", CFG_W'(bus.io_cfg_epoch), CFG_W'(255));
        end
        chk("epoch_wrap", CFG_W'(bus.io_cfg_epoch), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
